// File: rtl/mem_readout_merge.sv
// Drains 12 event memories in fixed priority order (lowest index first) into one
// 48-bit stream; emits a BX header word whenever no memory has items left.
module mem_readout_merge #(
  parameter int NMEM   = 12,
  parameter int DATA_W = 44,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_event,
  input  logic [2:0]          bx,
  input  logic [ADDR_W-1:0]   number_in1,
  input  logic [ADDR_W-1:0]   number_in2,
  input  logic [ADDR_W-1:0]   number_in3,
  input  logic [ADDR_W-1:0]   number_in4,
  input  logic [ADDR_W-1:0]   number_in5,
  input  logic [ADDR_W-1:0]   number_in6,
  input  logic [ADDR_W-1:0]   number_in7,
  input  logic [ADDR_W-1:0]   number_in8,
  input  logic [ADDR_W-1:0]   number_in9,
  input  logic [ADDR_W-1:0]   number_in10,
  input  logic [ADDR_W-1:0]   number_in11,
  input  logic [ADDR_W-1:0]   number_in12,
  output logic [ADDR_W-1:0]   read_add1,
  output logic [ADDR_W-1:0]   read_add2,
  output logic [ADDR_W-1:0]   read_add3,
  output logic [ADDR_W-1:0]   read_add4,
  output logic [ADDR_W-1:0]   read_add5,
  output logic [ADDR_W-1:0]   read_add6,
  output logic [ADDR_W-1:0]   read_add7,
  output logic [ADDR_W-1:0]   read_add8,
  output logic [ADDR_W-1:0]   read_add9,
  output logic [ADDR_W-1:0]   read_add10,
  output logic [ADDR_W-1:0]   read_add11,
  output logic [ADDR_W-1:0]   read_add12,
  input  logic [DATA_W-1:0]   mem_dat1,
  input  logic [DATA_W-1:0]   mem_dat2,
  input  logic [DATA_W-1:0]   mem_dat3,
  input  logic [DATA_W-1:0]   mem_dat4,
  input  logic [DATA_W-1:0]   mem_dat5,
  input  logic [DATA_W-1:0]   mem_dat6,
  input  logic [DATA_W-1:0]   mem_dat7,
  input  logic [DATA_W-1:0]   mem_dat8,
  input  logic [DATA_W-1:0]   mem_dat9,
  input  logic [DATA_W-1:0]   mem_dat10,
  input  logic [DATA_W-1:0]   mem_dat11,
  input  logic [DATA_W-1:0]   mem_dat12,
  output logic [DATA_W+3:0]   mem_dat_stream,
  output logic                valid,
  output logic                send_bx,
  output logic                none
);

  localparam logic [3:0] SEL_NONE = 4'hF;

  logic [ADDR_W-1:0] number_in_a [NMEM];
  logic [DATA_W-1:0] mem_dat_a   [NMEM];

  logic [ADDR_W-1:0] count_q [NMEM];
  logic [ADDR_W-1:0] count_d [NMEM];
  logic [ADDR_W-1:0] addr_q  [NMEM];
  logic [ADDR_W-1:0] addr_d  [NMEM];
  logic [NMEM-1:0]   valid_d1_q, valid_d1_d;
  logic [3:0]        sel_d1_q, sel_d1_d;
  logic              new_event_d1_q, new_event_d1_d;
  logic              new_event_d2_q, new_event_d2_d;
  logic [DATA_W+3:0] stream_q, stream_d;
  logic              valid_q, valid_d;
  logic              send_bx_q, send_bx_d;

  logic              setup_s;
  logic              any_count_s;
  logic [NMEM-1:0]   sel_oh_s;
  logic [3:0]        sel_s;
  logic [DATA_W-1:0] mux_dat_s;

  assign number_in_a[0]  = number_in1;
  assign number_in_a[1]  = number_in2;
  assign number_in_a[2]  = number_in3;
  assign number_in_a[3]  = number_in4;
  assign number_in_a[4]  = number_in5;
  assign number_in_a[5]  = number_in6;
  assign number_in_a[6]  = number_in7;
  assign number_in_a[7]  = number_in8;
  assign number_in_a[8]  = number_in9;
  assign number_in_a[9]  = number_in10;
  assign number_in_a[10] = number_in11;
  assign number_in_a[11] = number_in12;

  assign mem_dat_a[0]  = mem_dat1;
  assign mem_dat_a[1]  = mem_dat2;
  assign mem_dat_a[2]  = mem_dat3;
  assign mem_dat_a[3]  = mem_dat4;
  assign mem_dat_a[4]  = mem_dat5;
  assign mem_dat_a[5]  = mem_dat6;
  assign mem_dat_a[6]  = mem_dat7;
  assign mem_dat_a[7]  = mem_dat8;
  assign mem_dat_a[8]  = mem_dat9;
  assign mem_dat_a[9]  = mem_dat10;
  assign mem_dat_a[10] = mem_dat11;
  assign mem_dat_a[11] = mem_dat12;

  assign read_add1  = addr_q[0];
  assign read_add2  = addr_q[1];
  assign read_add3  = addr_q[2];
  assign read_add4  = addr_q[3];
  assign read_add5  = addr_q[4];
  assign read_add6  = addr_q[5];
  assign read_add7  = addr_q[6];
  assign read_add8  = addr_q[7];
  assign read_add9  = addr_q[8];
  assign read_add10 = addr_q[9];
  assign read_add11 = addr_q[10];
  assign read_add12 = addr_q[11];

  assign mem_dat_stream = stream_q;
  assign valid          = valid_q;
  assign send_bx        = send_bx_q;

  // Priority encoder: the first memory with items wins; nothing is selected during setup.
  always_comb begin
    setup_s     = new_event | new_event_d1_q | new_event_d2_q;
    sel_s       = SEL_NONE;
    sel_oh_s    = '0;
    any_count_s = 1'b0;
    for (int n = 0; n < NMEM; n++) begin
      any_count_s = any_count_s | (count_q[n] != '0);
      if ((count_q[n] != '0) && !setup_s && (sel_s == SEL_NONE)) begin
        sel_s       = 4'(n);
        sel_oh_s[n] = 1'b1;
      end else begin
        sel_oh_s[n] = 1'b0;
      end
    end
    none = !setup_s && !any_count_s;
  end

  always_comb begin
    for (int n = 0; n < NMEM; n++) begin
      if (new_event) begin
        count_d[n] = number_in_a[n];
        addr_d[n]  = '0;
      end else if (sel_oh_s[n]) begin
        count_d[n] = count_q[n] - ADDR_W'(1);
        addr_d[n]  = addr_q[n] + ADDR_W'(1);
      end else begin
        count_d[n] = count_q[n];
        addr_d[n]  = addr_q[n];
      end
    end
    valid_d1_d     = sel_oh_s;
    sel_d1_d       = sel_s;
    new_event_d1_d = new_event;
    new_event_d2_d = new_event_d1_q;

    // Read data for sel_d1 arrives now (memories have one cycle of read latency).
    mux_dat_s = '0;
    for (int n = 0; n < NMEM; n++) begin
      if (sel_d1_q == 4'(n)) begin
        mux_dat_s = mem_dat_a[n];
      end else begin
        mux_dat_s = mux_dat_s;
      end
    end

    if (sel_d1_q == SEL_NONE) begin
      stream_d = {SEL_NONE, {(DATA_W-3){1'b0}}, bx};
    end else begin
      stream_d = {sel_d1_q, mux_dat_s};
    end
    valid_d   = !setup_s && (|valid_d1_q);
    send_bx_d = !setup_s && (sel_d1_q == SEL_NONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NMEM; n++) begin
        count_q[n] <= '0;
        addr_q[n]  <= '0;
      end
      valid_d1_q     <= '0;
      sel_d1_q       <= 4'h0;
      new_event_d1_q <= 1'b0;
      new_event_d2_q <= 1'b0;
      stream_q       <= '0;
      valid_q        <= 1'b0;
      send_bx_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NMEM; n++) begin
        count_q[n] <= count_d[n];
        addr_q[n]  <= addr_d[n];
      end
      valid_d1_q     <= valid_d1_d;
      sel_d1_q       <= sel_d1_d;
      new_event_d1_q <= new_event_d1_d;
      new_event_d2_q <= new_event_d2_d;
      stream_q       <= stream_d;
      valid_q        <= valid_d;
      send_bx_q      <= send_bx_d;
    end
  end

endmodule

// File: tb/tb_mem_readout_merge.sv
// Randomized bench for mem_readout_merge: synchronous-read memory models plus a
// reference that lists the expected words of each event in drain order.
module tb_mem_readout_merge;

  logic        clk;
  logic        reset;
  logic        new_event;
  logic [2:0]  bx;
  logic [5:0]  number_in [12];
  logic [5:0]  read_add  [12];
  logic [43:0] mem_dat   [12];
  logic [43:0] mem_arr   [12][64];
  logic [47:0] mem_dat_stream;
  logic        valid;
  logic        send_bx;
  logic        none;

  int test_cnt = 0;
  int fail_cnt = 0;

  mem_readout_merge dut (
    .clk(clk), .reset(reset), .new_event(new_event), .bx(bx),
    .number_in1(number_in[0]),   .number_in2(number_in[1]),   .number_in3(number_in[2]),
    .number_in4(number_in[3]),   .number_in5(number_in[4]),   .number_in6(number_in[5]),
    .number_in7(number_in[6]),   .number_in8(number_in[7]),   .number_in9(number_in[8]),
    .number_in10(number_in[9]),  .number_in11(number_in[10]), .number_in12(number_in[11]),
    .read_add1(read_add[0]),     .read_add2(read_add[1]),     .read_add3(read_add[2]),
    .read_add4(read_add[3]),     .read_add5(read_add[4]),     .read_add6(read_add[5]),
    .read_add7(read_add[6]),     .read_add8(read_add[7]),     .read_add9(read_add[8]),
    .read_add10(read_add[9]),    .read_add11(read_add[10]),   .read_add12(read_add[11]),
    .mem_dat1(mem_dat[0]),       .mem_dat2(mem_dat[1]),       .mem_dat3(mem_dat[2]),
    .mem_dat4(mem_dat[3]),       .mem_dat5(mem_dat[4]),       .mem_dat6(mem_dat[5]),
    .mem_dat7(mem_dat[6]),       .mem_dat8(mem_dat[7]),       .mem_dat9(mem_dat[8]),
    .mem_dat10(mem_dat[9]),      .mem_dat11(mem_dat[10]),     .mem_dat12(mem_dat[11]),
    .mem_dat_stream(mem_dat_stream), .valid(valid), .send_bx(send_bx), .none(none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data follows the address by one clock.
  always @(posedge clk) begin
    for (int n = 0; n < 12; n++) mem_dat[n] <= mem_arr[n][read_add[n]];
  end

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] header_word(input logic [2:0] b);
    logic [47:0] w;
    w = '0;
    w[47:44] = 4'hF;
    w[2:0] = b;
    return w;
  endfunction

  task automatic fill_mems();
    for (int n = 0; n < 12; n++)
      for (int a = 0; a < 64; a++) mem_arr[n][a] = 44'({$urandom(), $urandom()});
  endtask

  task automatic set_counts(input int c0, input int c2, input int c6, input int c11);
    for (int n = 0; n < 12; n++) number_in[n] = 6'd0;
    number_in[0] = 6'(c0); number_in[2] = 6'(c2); number_in[6] = 6'(c6); number_in[11] = 6'(c11);
  endtask

  // Issue new_event, then check cycles 1..max_k after it against the expected word list.
  task automatic run_event(input int max_k);
    int s;
    int off [12];
    int cnt [12];
    int idx, m, ra;
    logic [47:0] exp_w;
    logic exp_v, exp_b;
    s = 0;
    for (int n = 0; n < 12; n++) begin
      cnt[n] = int'(number_in[n]);
      off[n] = s;
      s += cnt[n];
    end
    @(negedge clk); new_event = 1'b1;
    @(negedge clk); new_event = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      if (k > 1) @(negedge clk);
      exp_w = header_word(bx);
      if (k <= 3) begin
        exp_v = 1'b0; exp_b = 1'b0;
      end else if (k == 4 || (k - 5) >= s) begin
        exp_v = 1'b0; exp_b = 1'b1;
      end else begin
        exp_v = 1'b1; exp_b = 1'b0;
        idx = k - 5;
        m = 0;
        while (idx >= off[m] + cnt[m]) m++;
        exp_w = {4'(m), mem_arr[m][idx - off[m]]};
      end
      check_val("valid", 48'(valid), 48'(exp_v));
      check_val("send_bx", 48'(send_bx), 48'(exp_b));
      if (exp_v || exp_b) check_val("stream", mem_dat_stream, exp_w);
      check_val("none", 48'(none), 48'((k >= 3) && (k - 3 >= s)));
      for (int n = 0; n < 12; n++) begin
        ra = k - 3 - off[n];
        if (ra < 0) ra = 0;
        if (ra > cnt[n]) ra = cnt[n];
        check_val("read_add", 48'(read_add[n]), 48'(ra));
      end
    end
  endtask

  // After a reset: no data, headers from the third sampled cycle on, addresses stay 0.
  task automatic check_idle(input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      check_val("idle_valid", 48'(valid), 48'd0);
      check_val("idle_none", 48'(none), 48'd1);
      check_val("idle_add1", 48'(read_add[0]), 48'd0);
      if (k >= 3) begin
        check_val("idle_send_bx", 48'(send_bx), 48'd1);
        check_val("idle_stream", mem_dat_stream, header_word(bx));
      end
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_valid", 48'(valid), 48'd0);
    check_val("rst_send_bx", 48'(send_bx), 48'd0);
    check_val("rst_stream", mem_dat_stream, 48'd0);
    check_val("rst_none", 48'(none), 48'd1);
    for (int n = 0; n < 12; n++) check_val("rst_add", 48'(read_add[n]), 48'd0);
  endtask

  initial begin
    reset = 1'b1;
    new_event = 1'b0;
    bx = 3'd5;
    for (int n = 0; n < 12; n++) number_in[n] = 6'd0;
    fill_mems();
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    check_idle(5);

    // Single memory, three items
    bx = 3'd2;
    set_counts(3, 0, 0, 0);
    run_event(12);

    // Sparse memories 3, 7, 12 drained back to back
    fill_mems();
    bx = 3'd6;
    set_counts(0, 2, 1, 2);
    run_event(14);

    // Empty event: headers right after setup
    bx = 3'd1;
    set_counts(0, 0, 0, 0);
    run_event(8);

    // Abort a long drain halfway, restart with new counts
    set_counts(40, 0, 0, 0);
    run_event(23);
    fill_mems();
    bx = 3'd3;
    set_counts(4, 3, 0, 5);
    number_in[4] = 6'd2;
    run_event(22);

    // Random events, occasionally aborted early
    for (int e = 0; e < 16; e++) begin
      int sum;
      fill_mems();
      bx = 3'($urandom_range(0, 7));
      sum = 0;
      for (int n = 0; n < 12; n++) begin
        number_in[n] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
        sum += int'(number_in[n]);
      end
      if ($urandom_range(0, 3) == 0) run_event(int'($urandom_range(5, 30)));
      else run_event(sum + 8);
    end

    // Async reset pulse between edges mid-drain
    bx = 3'd4;
    set_counts(40, 0, 0, 0);
    run_event(12);
    #2 reset = 1'b1;
    #1 check_reset_state();
    @(negedge clk); reset = 1'b0;
    check_idle(6);

    // Reset dominates new_event
    set_counts(9, 9, 9, 9);
    @(negedge clk); reset = 1'b1; new_event = 1'b1;
    @(negedge clk); new_event = 1'b0;
    #1 check_reset_state();
    @(negedge clk); reset = 1'b0;
    check_idle(4);

    // Recovery after reset
    fill_mems();
    bx = 3'd7;
    set_counts(1, 0, 2, 1);
    run_event(14);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
